// File: rtl/sd_pkg.sv
// sd_pkg: shared SD clock constants and run-state type.
package sd_pkg;
  localparam int SD_DIV_WIDTH = 8;
  localparam int SD_INIT_DIV = 64;
  localparam int SD_FAST_DIV = 1;
  typedef enum logic {SD_CLK_STOPPED, SD_CLK_RUNNING} sd_run_e;
endpackage

// File: rtl/sd_clock_gen.sv
// sd_clock_gen: glitch-free programmable 50% SD clock with rise/fall strobes.
// Define SD_CLK_GATE_EN to honour ien; otherwise the clock free-runs after reset.
module sd_clock_gen
  import sd_pkg::*;
#(
  parameter int DIV_WIDTH = SD_DIV_WIDTH,
  parameter int INIT_DIV = SD_INIT_DIV
) (
  input  logic                 iclk,
  input  logic                 irst_n,
  input  logic [DIV_WIDTH-1:0] idiv,
  input  logic                 ien,
  output logic                 oclk,
  output logic                 orun,
  output logic                 orise,
  output logic                 ofall
);
`ifdef SD_CLK_GATE_EN
  localparam logic GATE = 1'b1;
`else
  localparam logic GATE = 1'b0;
`endif
  localparam logic [DIV_WIDTH-1:0] RST_DIV = (INIT_DIV == 0) ? DIV_WIDTH'(1) : DIV_WIDTH'(INIT_DIV);
  sd_run_e st;
  logic [DIV_WIDTH-1:0] cnt, div, nxt_div;
  logic en;
  assign en = ien | ~GATE;
  assign nxt_div = (idiv == '0) ? DIV_WIDTH'(1) : idiv;
  assign orun = (st == SD_CLK_RUNNING);
  // divisor only reloads at the start of a low phase so a high phase is never resized
  always_ff @(posedge iclk or negedge irst_n)
    if (!irst_n) begin
      st <= SD_CLK_STOPPED;
      oclk <= 1'b0;
      cnt <= '0;
      div <= RST_DIV;
      orise <= 1'b0;
      ofall <= 1'b0;
    end else begin
      orise <= 1'b0;
      ofall <= 1'b0;
      if (st == SD_CLK_STOPPED) begin
        if (en) begin
          st <= SD_CLK_RUNNING;
          if (GATE) div <= nxt_div;
        end
      end else if (!en && !oclk) begin
        st <= SD_CLK_STOPPED;
        cnt <= '0;
      end else if (cnt == div - DIV_WIDTH'(1)) begin
        cnt <= '0;
        oclk <= ~oclk;
        orise <= ~oclk;
        ofall <= oclk;
        if (oclk) begin
          div <= nxt_div;
          if (!en) st <= SD_CLK_STOPPED;
        end
      end else cnt <= cnt + DIV_WIDTH'(1);
    end
endmodule

// File: doc/sd_clock_gen.md
# sd_clock_gen

Programmable SD-card clock generator replacing the fixed /2 and /128 divider pair. Produces one 50 %-duty SD clock whose divisor is changed at run time without glitches, can be stopped low and restarted on request, and emits single-cycle rise/fall strobes so the command and data paths can launch and sample in the reference clock domain. Sits between the system clock and the SD command/data engines; the identification phase uses a slow divisor and transfer phase a fast one, both through this block.

## Interface
- DIV_WIDTH, 8, width of the divisor and half-period counter
- INIT_DIV, 64, divisor loaded at reset (64 gives iclk/128)
- iclk  in  1  reference clock; all logic on its rising edge
- irst_n  in  1  reset, asynchronous, active-low
- idiv  in  DIV_WIDTH  requested divisor D; SD clock period = 2·D iclk cycles; 0 treated as 1
- ien  in  1  run request (1 = clock runs, 0 = park clock low)
- oclk  out  1  SD clock, registered
- orun  out  1  1 while the generator is running
- orise  out  1  one-cycle pulse in the first iclk cycle oclk is high
- ofall  out  1  one-cycle pulse in the first iclk cycle oclk is low after a high phase

## Operation
- Reset (asserted any time, including mid-phase): immediately oclk=0, orun=0, orise=0, ofall=0, counter=0, active divisor=INIT_DIV (0 mapped to 1).
- States: STOPPED (orun=0, oclk=0, counter=0) and RUNNING (orun=1).
- STOPPED -> RUNNING: on an edge with ien=1; active divisor <= idiv, counter stays 0.
- RUNNING: counter increments each cycle; when counter == active divisor-1, counter <= 0 and oclk toggles.
- Rising toggle (oclk 0->1): orise=1 for that cycle.
- Falling toggle (oclk 1->0): ofall=1 for that cycle; active divisor <= idiv. Divisor changes therefore take effect only at the start of a low phase; a high phase is never shortened or lengthened.
- RUNNING -> STOPPED with ien=0: if oclk=0, stop at the next edge (low phase truncated, clock already low, no glitch); if oclk=1, complete the high phase and stop at the falling toggle (ofall still pulses). orise never pulses on a stop edge.
- ien toggling back to 1 during a high phase cancels the pending stop.
- idiv changes mid-phase are ignored until the next falling toggle or STOPPED->RUNNING edge.
- Counter arithmetic modulo 2^DIV_WIDTH; comparison against active divisor-1 never overflows since active divisor ≥ 1.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Start latency: orun rises one edge after ien=1 is sampled; oclk rises at the D-th edge after orun rises.
- High and low phases each exactly D iclk cycles while running; D=1 gives iclk/2 continuous toggle, orise/ofall alternate every cycle.
- Stop latency: ≤ D cycles (from high phase), 1 cycle (from low phase).

## Configuration
- SD_CLK_GATE_EN defined: ien honoured as above.
- Undefined: ien ignored (port kept); orun goes 1 on the first edge after reset release and never returns to 0 except by reset; divisor still updates at each falling toggle.

## Structure
- Shared package sd_pkg: SD_DIV_WIDTH=8, SD_INIT_DIV=64 (identification, ≤400 kHz from 50 MHz), SD_FAST_DIV=1, run-state enum {SD_CLK_STOPPED, SD_CLK_RUNNING}.
- Single module; no sub-module warranted.

## Test plan
- Reset release, ien=1, idiv=64 -> orun=1 one cycle later; oclk rises at 64th edge thereafter; period 128 cycles; orise/ofall each once per period.
- idiv=1 running -> oclk toggles every cycle, orise and ofall alternate every cycle, no missing pulse.
- Running D=64, change idiv to 2 at cycle 10 of a high phase -> high phase stays 64 cycles; following low and high phases 2 cycles each.
- Drop ien at cycle 5 of high phase (D=8) -> oclk stays high 3 more cycles, then 0 with ofall, orun=0 same edge; ien at cycle 2 of low phase -> orun=0 next edge, oclk stays 0.
- Assert irst_n=0 mid high phase -> oclk, orun, strobes 0 without waiting for an edge; active divisor back to 64.
- Build without SD_CLK_GATE_EN, hold ien=0 -> clock runs at INIT_DIV, orun=1 after first edge.
